// File: rtl/riscvibe_pkg.sv
// Shared RISC-Vibe types and helpers used by the fetch-PC unit.
package riscvibe_pkg;

    typedef enum logic [1:0] {
        PC_BOOT,
        PC_RUN,
        PC_HALT
    } pc_state_t;

    // Sequential PC increment in bytes for a given instruction alignment in bits.
    function automatic int unsigned pc_incr(input int unsigned ialign);
        return ialign / 8;
    endfunction

    // Only the two low address bits ever matter for 16/32-bit alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input int unsigned ialign);
        if (ialign == 16) begin
            return addr_lo[0];
        end
        return |addr_lo;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry holding register for a redirect that arrived while a fetch request was stalled.
module pc_redirect_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set,
    input  logic [XLEN-1:0] data,
    input  logic            consume,
    input  logic            clear,
    output logic            valid,
    output logic [XLEN-1:0] target
);

    logic            valid_q;
    logic [XLEN-1:0] target_q;

    // A newer set simply overwrites the stored target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else if (clear || consume) begin
            valid_q  <= 1'b0;
        end else if (set) begin
            valid_q  <= 1'b1;
            target_q <= data;
        end
    end

    assign valid  = valid_q;
    assign target = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: holds the fetch PC, issues it over valid/ready and applies
// trap / branch redirects, deferring redirects that hit a stalled request.
module pc_gen
    import riscvibe_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     IALIGN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    localparam int unsigned INCR = pc_incr(IALIGN);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            hold_q, hold_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;

    logic            accept;
    logic            pend_set, pend_consume, pend_clear;
    logic            pend_valid;
    logic [XLEN-1:0] pend_target;

    pc_redirect_buf #(
        .XLEN(XLEN)
    ) u_redirect_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (pend_set),
        .data    (redirect_target),
        .consume (pend_consume),
        .clear   (pend_clear),
        .valid   (pend_valid),
        .target  (pend_target)
    );

    // hold_q marks a request already on the bus; it is never retracted by stall.
    assign fetch_valid = (state_q == PC_RUN) && (!stall || hold_q);
    assign accept      = fetch_valid && fetch_ready;
    assign pc_next_seq = pc_q + XLEN'(INCR);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = fetch_valid && !fetch_ready;
        mis_d        = 1'b0;
        mis_addr_d   = mis_addr_q;
        pend_set     = 1'b0;
        pend_consume = 1'b0;
        pend_clear   = 1'b0;

        if (state_q == PC_BOOT) begin
            state_d = PC_RUN;
        end

        if (trap_valid) begin
            // A trap flushes any outstanding fetch, so it may change pc mid-handshake.
            pc_d       = trap_target;
            pend_clear = 1'b1;
            hold_d     = 1'b0;
            state_d    = PC_RUN;
        end else if (redirect_valid && (state_q != PC_HALT)) begin
            if (is_misaligned(redirect_target[1:0], IALIGN)) begin
                mis_d      = 1'b1;
                mis_addr_d = redirect_target;
                state_d    = PC_HALT;
                pend_clear = 1'b1;
                hold_d     = 1'b0;
            end else if (!fetch_valid || accept) begin
                pc_d       = redirect_target;
                pend_clear = 1'b1;
            end else begin
                pend_set = 1'b1;
            end
        end else if (accept) begin
            pc_d         = pend_valid ? pend_target : pc_next_seq;
            pend_consume = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PC_BOOT;
            pc_q       <= RESET_VECTOR;
            hold_q     <= 1'b0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    assign fetch_pc      = pc_q;
    assign misalign      = mis_q;
    assign misalign_addr = mis_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: accepted fetch addresses are scoreboarded,
// control outputs are checked directly at points of interest.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect_valid, trap_valid, fetch_ready;
    logic [31:0] redirect_target, trap_target;
    logic        fetch_valid, misalign;
    logic [31:0] fetch_pc, pc_next_seq, misalign_addr;

    // Second instance with 16-bit alignment.
    logic        c_rst_n, c_redirect_valid, c_fetch_ready;
    logic [31:0] c_redirect_target;
    logic        c_fetch_valid, c_misalign;
    logic [31:0] c_fetch_pc, c_pc_next_seq, c_misalign_addr;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];
    logic        sb_en = 1'b0;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .IALIGN(32)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_pc        (fetch_pc),
        .pc_next_seq     (pc_next_seq),
        .misalign        (misalign),
        .misalign_addr   (misalign_addr)
    );

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .IALIGN(16)
    ) u_dut16 (
        .clk             (clk),
        .rst_n           (c_rst_n),
        .stall           (1'b0),
        .redirect_valid  (c_redirect_valid),
        .redirect_target (c_redirect_target),
        .trap_valid      (1'b0),
        .trap_target     (32'h0),
        .fetch_valid     (c_fetch_valid),
        .fetch_ready     (c_fetch_ready),
        .fetch_pc        (c_fetch_pc),
        .pc_next_seq     (c_pc_next_seq),
        .misalign        (c_misalign),
        .misalign_addr   (c_misalign_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr);
        exp_q.push_back(addr);
    endtask

    // Every accepted request must match the next address the bench predicted.
    always @(negedge clk) begin
        if (sb_en && rst_n && fetch_valid && fetch_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_accept", fetch_pc, 32'hDEAD_BEEF);
            end else begin
                check("sb_pc", fetch_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
        redirect_target = '0; trap_target = '0; fetch_ready = 1'b1;
        c_rst_n = 1'b0; c_redirect_valid = 1'b0; c_redirect_target = '0; c_fetch_ready = 1'b1;

        // Reset and boot
        #3;
        check("rst_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_pc", fetch_pc, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        check("rst_mis_addr", misalign_addr, 32'h0);
        #9 rst_n = 1'b1;
        #1 check("boot_valid", {31'b0, fetch_valid}, 32'h0);
        sb_en = 1'b1;
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        tick();
        check("run_valid", {31'b0, fetch_valid}, 32'h1);
        check("run_pc0", fetch_pc, 32'h0);
        tick(); check("run_pc4", fetch_pc, 32'h4);
        tick(); check("run_pc8", fetch_pc, 32'h8);
        tick(); tick();
        check("run_pc10", fetch_pc, 32'h10);

        // Handshake hold
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_pc", fetch_pc, 32'h10);
            check("hold_valid", {31'b0, fetch_valid}, 32'h1);
        end
        fetch_ready = 1'b1; push(32'h10);
        tick(); check("hold_release", fetch_pc, 32'h14);

        // Redirect with accept applies directly
        push(32'h14);
        redirect_valid = 1'b1; redirect_target = 32'h20;
        tick(); redirect_valid = 1'b0; fetch_ready = 1'b0;
        check("redir_direct", fetch_pc, 32'h20);

        // Pending redirect
        redirect_valid = 1'b1; redirect_target = 32'h100;
        tick(); redirect_valid = 1'b0;
        check("pend_hold", fetch_pc, 32'h20);
        check("pend_valid", {31'b0, fetch_valid}, 32'h1);
        tick(); check("pend_hold2", fetch_pc, 32'h20);
        fetch_ready = 1'b1; push(32'h20);
        tick(); fetch_ready = 1'b0;
        check("pend_apply", fetch_pc, 32'h100);

        // Newest pending redirect wins
        redirect_valid = 1'b1; redirect_target = 32'h100;
        tick(); redirect_target = 32'h200;
        tick(); redirect_valid = 1'b0;
        check("pend2_hold", fetch_pc, 32'h100);
        fetch_ready = 1'b1; push(32'h100);
        tick(); fetch_ready = 1'b0;
        check("pend2_apply", fetch_pc, 32'h200);

        // Trap beats redirect and clears pending
        redirect_valid = 1'b1; redirect_target = 32'h300;
        tick();
        trap_valid = 1'b1; trap_target = 32'h80; redirect_target = 32'h100;
        tick(); trap_valid = 1'b0; redirect_valid = 1'b0;
        check("prio_trap", fetch_pc, 32'h80);
        fetch_ready = 1'b1; push(32'h80);
        tick(); fetch_ready = 1'b0;
        check("prio_no_pend", fetch_pc, 32'h84);

        // Misaligned redirect halts fetch
        redirect_valid = 1'b1; redirect_target = 32'h102;
        tick(); redirect_valid = 1'b0;
        check("mis_pulse", {31'b0, misalign}, 32'h1);
        check("mis_addr", misalign_addr, 32'h102);
        check("mis_valid", {31'b0, fetch_valid}, 32'h0);
        check("mis_pc", fetch_pc, 32'h84);
        fetch_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h40;
        tick(); redirect_valid = 1'b0;
        check("mis_one_cycle", {31'b0, misalign}, 32'h0);
        check("mis_addr_held", misalign_addr, 32'h102);
        check("halt_ignore", fetch_pc, 32'h84);
        check("halt_valid", {31'b0, fetch_valid}, 32'h0);
        trap_valid = 1'b1; trap_target = 32'h80;
        tick(); trap_valid = 1'b0;
        check("halt_exit_pc", fetch_pc, 32'h80);
        check("halt_exit_valid", {31'b0, fetch_valid}, 32'h1);
        push(32'h80);
        tick(); check("resume_seq", fetch_pc, 32'h84);

        // Stall with no outstanding request
        stall = 1'b1;
        #1 check("stall_valid", {31'b0, fetch_valid}, 32'h0);
        tick(); check("stall_pc", fetch_pc, 32'h84);
        redirect_valid = 1'b1; redirect_target = 32'h200;
        tick(); redirect_valid = 1'b0;
        check("stall_redir", fetch_pc, 32'h200);

        // Stall never retracts an outstanding request
        stall = 1'b0; fetch_ready = 1'b0;
        tick();
        stall = 1'b1;
        #1 check("stall_no_retract", {31'b0, fetch_valid}, 32'h1);
        fetch_ready = 1'b1; push(32'h200);
        tick();
        check("stall_after_pc", fetch_pc, 32'h204);
        check("stall_after_valid", {31'b0, fetch_valid}, 32'h0);

        // Wrap-around
        stall = 1'b0; fetch_ready = 1'b0;
        trap_valid = 1'b1; trap_target = 32'hFFFF_FFFC;
        tick(); trap_valid = 1'b0;
        check("wrap_pc", fetch_pc, 32'hFFFF_FFFC);
        check("wrap_seq", pc_next_seq, 32'h0);
        fetch_ready = 1'b1; push(32'hFFFF_FFFC);
        tick(); check("wrap_zero", fetch_pc, 32'h0);
        push(32'h0);
        tick(); fetch_ready = 1'b0;
        check("wrap_next", fetch_pc, 32'h4);

        // Asynchronous reset mid-cycle, with a pending redirect stored
        redirect_valid = 1'b1; redirect_target = 32'h500;
        tick(); redirect_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("arst_pc", fetch_pc, 32'h0);
        check("arst_valid", {31'b0, fetch_valid}, 32'h0);
        check("arst_mis_addr", misalign_addr, 32'h0);
        tick(); rst_n = 1'b1; fetch_ready = 1'b1;
        push(32'h0);
        tick(); check("arst_boot_pc", fetch_pc, 32'h0);
        tick(); fetch_ready = 1'b0;
        check("arst_no_pend", fetch_pc, 32'h4);
        check("sb_drain", exp_q.size(), 32'h0);

        // IALIGN=16 instance
        c_rst_n = 1'b1;
        tick();
        check("c16_pc0", c_fetch_pc, 32'h0);
        c_redirect_valid = 1'b1; c_redirect_target = 32'h102;
        tick(); c_redirect_valid = 1'b0;
        check("c16_redir", c_fetch_pc, 32'h102);
        check("c16_no_mis", {31'b0, c_misalign}, 32'h0);
        tick();
        check("c16_inc", c_fetch_pc, 32'h104);
        check("c16_seq", c_pc_next_seq, 32'h106);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
